// File: rtl/capture_pretrig.sv
// Pre-trigger capture front end: clock-enable sampler, circular history buffer and AXI-Stream drain.
// Optional macro CAPTURE_TIMESTAMP_EN adds o_tuser, the signed sample index relative to the trigger.

module capture_pretrig #(
  parameter int DSIZE     = 32,
  parameter int MAX_DIV   = 32,
  parameter int PRE_DEPTH = 256,
  parameter int SADDR_W   = 24,
  localparam int CW = $clog2(MAX_DIV),
  localparam int AW = $clog2(PRE_DEPTH)
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [DSIZE-1:0]   i_dinput,
  input  logic [CW-1:0]      i_ckdiv,
  input  logic               i_arm,
  input  logic               i_abort,
  input  logic               i_trig_hit,
  input  logic [AW-1:0]      i_pre_trigger_count,
  input  logic [SADDR_W-1:0] i_post_trigger_count,
  output logic               o_sample_en,
  output logic [DSIZE-1:0]   o_sample_data,
  output logic [DSIZE-1:0]   o_tdata,
  output logic               o_tvalid,
  input  logic               i_tready,
  output logic               o_tlast,
  output logic               o_armed,
  output logic               o_triggered,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_overrun,
  output logic [15:0]        o_drop_count
`ifdef CAPTURE_TIMESTAMP_EN
  ,
  output logic [31:0]        o_tuser
`endif
);

  // state   | meaning
  // S_IDLE  | waiting for arm
  // S_FILL  | collecting the first pre-trigger samples, trigger ignored
  // S_ARMED | sliding pre-trigger window, waiting for a qualified trigger
  // S_POST  | buffer is a FIFO: post samples in, stream out
  // S_FLUSH | draining what is left, tlast on the final stored sample
  typedef enum logic [2:0] {S_IDLE, S_FILL, S_ARMED, S_POST, S_FLUSH} state_t;

  localparam logic [AW-1:0]      PTR_ONE  = 1;
  localparam logic [AW:0]        OCC_ONE  = 1;
  localparam logic [AW:0]        OCC_TWO  = 2;
  localparam logic [AW:0]        OCC_FULL = (AW+1)'(PRE_DEPTH);
  localparam logic [AW-1:0]      PRE_MAX  = AW'(PRE_DEPTH - 2);
  localparam logic [SADDR_W-1:0] POST_ONE = 1;
  localparam logic [CW-1:0]      DIV_ONE  = 1;

  state_t r_state, w_state_nxt;

  logic [CW-1:0]      r_div_cnt, r_ckdiv_q;
  logic               r_sample_en;
  logic [DSIZE-1:0]   r_sample_data;
  logic [DSIZE-1:0]   r_mem [PRE_DEPTH];
  logic [AW-1:0]      r_wptr, r_rptr;
  logic [AW:0]        r_occ;
  logic [AW-1:0]      r_pre;
  logic [SADDR_W-1:0] r_post;
  logic [DSIZE-1:0]   r_tdata;
  logic               r_tvalid, r_tlast;
  logic               r_overrun;
  logic [15:0]        r_drop_count;

  logic               w_ckdiv_chg, w_tick;
  logic               w_samp, w_trig, w_hs, w_stream, w_full, w_final;
  logic               w_wr, w_drop, w_discard, w_dec;
  logic               w_load, w_load_last;
  logic [AW-1:0]      w_load_addr;
  logic [AW-1:0]      w_pre_clamp;
  logic [SADDR_W-1:0] w_post_clamp;
  logic [AW:0]        w_pre_ext;

  // A new divisor restarts the phase instead of letting the counter run past it.
  assign w_ckdiv_chg = (i_ckdiv != r_ckdiv_q);
  assign w_tick      = !w_ckdiv_chg && (r_div_cnt == i_ckdiv);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_div_cnt     <= '0;
      r_ckdiv_q     <= '0;
      r_sample_en   <= 1'b0;
      r_sample_data <= '0;
    end else begin
      r_ckdiv_q   <= i_ckdiv;
      r_sample_en <= w_tick;
      if (w_tick)
        r_sample_data <= i_dinput;
      if (w_ckdiv_chg || w_tick)
        r_div_cnt <= '0;
      else
        r_div_cnt <= r_div_cnt + DIV_ONE;
    end
  end

  assign w_pre_clamp  = (i_pre_trigger_count > PRE_MAX) ? PRE_MAX : i_pre_trigger_count;
  assign w_post_clamp = (i_post_trigger_count == '0) ? POST_ONE : i_post_trigger_count;
  assign w_pre_ext    = {1'b0, r_pre};

  assign w_samp   = r_sample_en;
  assign w_trig   = (r_state == S_ARMED) && w_samp && i_trig_hit;
  assign w_hs     = r_tvalid && i_tready;
  assign w_stream = (r_state == S_POST) || (r_state == S_FLUSH);
  assign w_full   = (r_occ == OCC_FULL);
  assign w_final  = (r_state == S_FLUSH) ||
                    ((r_state == S_POST) && w_samp && (r_post == POST_ONE));
  assign w_dec    = w_hs || w_discard;

  always_ff @(posedge i_clk) begin
    if (i_reset)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_arm) w_state_nxt = (w_pre_clamp == '0) ? S_ARMED : S_FILL;
      S_FILL:  if (w_samp && ((r_occ + OCC_ONE) == w_pre_ext)) w_state_nxt = S_ARMED;
      S_ARMED: if (w_trig) w_state_nxt = (r_post == POST_ONE) ? S_FLUSH : S_POST;
      S_POST:  if (w_samp && (r_post == POST_ONE)) w_state_nxt = S_FLUSH;
      S_FLUSH: if (w_hs && r_tlast) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (i_abort)
      w_state_nxt = S_IDLE;
  end

  // The output register counts as occupied: its entry stays at r_rptr until handshake.
  always_comb begin
    w_wr        = 1'b0;
    w_drop      = 1'b0;
    w_discard   = 1'b0;
    w_load      = 1'b0;
    w_load_last = 1'b0;
    w_load_addr = r_rptr;
    case (r_state)
      S_FILL:  w_wr = w_samp;
      S_ARMED: begin
        w_wr      = w_samp;
        w_discard = w_samp && !i_trig_hit && (r_occ == w_pre_ext);
      end
      S_POST: begin
        w_wr   = w_samp && !w_full;
        w_drop = w_samp && w_full;
      end
      default: ;
    endcase
    if (w_stream) begin
      if (w_hs) begin
        w_load      = (r_occ > OCC_ONE);
        w_load_addr = r_rptr + PTR_ONE;
        w_load_last = w_final && !w_wr && (r_occ == OCC_TWO);
      end else if (!r_tvalid) begin
        w_load      = (r_occ != '0);
        w_load_last = w_final && !w_wr && (r_occ == OCC_ONE);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr)
      r_mem[r_wptr] <= r_sample_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_occ        <= '0;
      r_pre        <= '0;
      r_post       <= '0;
      r_tdata      <= '0;
      r_tvalid     <= 1'b0;
      r_tlast      <= 1'b0;
      r_overrun    <= 1'b0;
      r_drop_count <= '0;
    end else if (i_abort) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_occ    <= '0;
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) && i_arm) begin
        r_pre        <= w_pre_clamp;
        r_post       <= w_post_clamp;
        r_overrun    <= 1'b0;
        r_drop_count <= '0;
        r_wptr       <= '0;
        r_rptr       <= '0;
        r_occ        <= '0;
      end
      if (w_wr)
        r_wptr <= r_wptr + PTR_ONE;
      if (w_dec)
        r_rptr <= r_rptr + PTR_ONE;
      if (w_wr && !w_dec)
        r_occ <= r_occ + OCC_ONE;
      else if (!w_wr && w_dec)
        r_occ <= r_occ - OCC_ONE;
      // Dropped post samples still count toward the post length.
      if (w_trig || ((r_state == S_POST) && w_samp))
        r_post <= r_post - POST_ONE;
      if (w_drop) begin
        r_overrun <= 1'b1;
        if (r_drop_count != 16'hFFFF)
          r_drop_count <= r_drop_count + 16'd1;
      end
      if (w_load) begin
        r_tdata  <= r_mem[w_load_addr];
        r_tvalid <= 1'b1;
        r_tlast  <= w_load_last;
      end else if (w_hs) begin
        r_tvalid <= 1'b0;
        r_tlast  <= 1'b0;
      end
    end
  end

`ifdef CAPTURE_TIMESTAMP_EN
  logic [31:0] r_abs, r_trig_abs, r_tuser;
  logic [31:0] r_imem [PRE_DEPTH];

  always_ff @(posedge i_clk) begin
    if (w_wr)
      r_imem[r_wptr] <= r_abs;
  end

  // Absolute sample numbers are stored; the index is relative to the trigger's number.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_abs      <= '0;
      r_trig_abs <= '0;
      r_tuser    <= '0;
    end else if (!i_abort) begin
      if ((r_state == S_IDLE) && i_arm)
        r_abs <= '0;
      else if (w_samp && ((r_state == S_FILL) || (r_state == S_ARMED) || (r_state == S_POST)))
        r_abs <= r_abs + 32'd1;
      if (w_trig)
        r_trig_abs <= r_abs;
      if (w_load)
        r_tuser <= r_imem[w_load_addr] - r_trig_abs;
    end
  end

  assign o_tuser = r_tuser;
`endif

  assign o_sample_en   = r_sample_en;
  assign o_sample_data = r_sample_data;
  assign o_tdata       = r_tdata;
  assign o_tvalid      = r_tvalid;
  assign o_tlast       = r_tlast;
  assign o_armed       = (r_state == S_ARMED);
  assign o_triggered   = (r_state == S_POST) || (r_state == S_FLUSH);
  assign o_busy        = (r_state != S_IDLE);
  assign o_done        = r_tvalid && i_tready && r_tlast;
  assign o_overrun     = r_overrun;
  assign o_drop_count  = r_drop_count;

endmodule

// File: doc/capture_pretrig.md
Name: capture_pretrig

Overview:
Single-clock successor to the sampling/capture front end. Samples dinput on an internally generated clock-enable strobe, with no derived sample clock. Keeps a circular pre-trigger history and, on trigger, streams the pre-trigger history followed by post-trigger samples over AXI-Stream with tlast. Sits between the input pins, the trigger matcher (fed by sample_data and sample_en) and the external DMA FIFO.

Parameters:
DSIZE, 32, sample width in bits
MAX_DIV, 32, maximum clock-enable divider; ckdiv width is $clog2(MAX_DIV)
PRE_DEPTH, 256, buffer depth in samples; must be a power of 2, at least 4
SADDR_W, 24, post-trigger counter width

Ports:
clk  in  1  single clock for all logic
reset  in  1  synchronous, active-high
dinput  in  DSIZE  raw input sample
ckdiv  in  $clog2(MAX_DIV)  sample period minus 1, in clk cycles
arm  in  1  level; start a capture when in IDLE
abort  in  1  one-cycle pulse; cancel capture
trig_hit  in  1  trigger matcher result for sample_data; qualified by sample_en
pre_trigger_count  in  $clog2(PRE_DEPTH)  number of pre-trigger samples to keep
post_trigger_count  in  SADDR_W  number of post-trigger samples, including the trigger sample
sample_en  out  1  one-cycle strobe marking a new sample_data
sample_data  out  DSIZE  registered sample, fed to the trigger matcher
tdata  out  DSIZE  stream data
tvalid  out  1  stream valid
tready  in  1  stream ready
tlast  out  1  final beat of a capture
armed  out  1  high in ARMED state
triggered  out  1  high in POST and FLUSH states
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse on the tlast handshake
overrun  out  1  sticky; cleared on the next arm
drop_count  out  16  samples dropped in the current capture; saturates at 16'hFFFF

Behaviour:
- Reset values: every output is 0; state is IDLE; pointers and counters are 0.
- Divider:
  - The counter counts 0..ckdiv; sample_en pulses when the counter equals ckdiv, so the sample period is ckdiv+1 cycles.
  - ckdiv=0 gives sample_en every cycle.
  - A change in ckdiv (compared against a registered copy) zeroes the counter; no sample_en fires in that cycle.
- Sampling: on sample_en, sample_data <= dinput. trig_hit is evaluated in the cycle after sample_en, i.e. against the new sample_data.
- Arm latches: in IDLE, arm=1 latches pre_trigger_count (clamped to PRE_DEPTH-2) and post_trigger_count, where 0 is treated as 1. It also clears overrun and drop_count.
- IDLE: when arm=1, go to FILL, or to ARMED if the latched pre count is 0.
- FILL:
  - Each sample is written to the buffer at the write pointer, which then increments.
  - When the number of stored samples equals the latched pre count, go to ARMED.
  - trig_hit is ignored in FILL.
- ARMED:
  - Each sample is written.
  - Once more than the pre count is stored, the read pointer advances with the write pointer, so the buffer holds exactly the last pre-count samples.
  - A qualified trig_hit goes to POST. The trigger sample is written as the first post sample.
- POST:
  - The buffer acts as a FIFO: the write side takes each sample_en, the read side drains to the stream.
  - The post counter decrements per written sample; when it reaches 0, go to FLUSH.
  - FIFO full (occupancy = PRE_DEPTH) at sample_en: the sample is not written, overrun is set, drop_count increments, and the post counter still decrements.
- FLUSH: drain the remaining samples. tlast is asserted on the last stored sample. After its handshake, pulse done and return to IDLE.
- Stream:
  - The output register is loaded from buffer read data. Latency from write to tvalid is at least 2 cycles.
  - tdata, tvalid and tlast are held stable while tvalid=1 and tready=0.
  - The read pointer advances only on a tvalid&tready handshake.
  - Simultaneous read and write in the same cycle: occupancy is unchanged.
- Beat count: total beats = latched pre count + post count - drop_count.
- abort, in any state: go to IDLE next cycle, zero the pointers, drop tvalid, keep overrun and drop_count. abort overrides arm and trig_hit in the same cycle.
- Pointer wrap: pointers are $clog2(PRE_DEPTH) bits and wrap modulo PRE_DEPTH. Occupancy is tracked in a separate counter of $clog2(PRE_DEPTH)+1 bits.

Optional Feature:
CAPTURE_TIMESTAMP_EN
- Defined: adds output tuser [31:0], signed sample index relative to the trigger.
  - The trigger sample is 0; pre samples are -pre..-1; post samples are 1, 2, ...
  - Dropped samples still consume an index.
  - tuser follows the same hold rule as tdata.
- Undefined: no tuser port and no index logic.

Test Plan:
- ckdiv=3, with a ckdiv change to 1 mid-run -> sample_en every 4 cycles; after the change the counter restarts and sample_en then fires every 2 cycles.
- pre=4, post=4, ramp input 0,1,2,..., trigger on value 10, tready=1 -> 8 beats 6..13, tlast on 13, done pulse, overrun=0.
- pre=0, post=0, trigger on value 5 -> 1 beat, value 5, with tlast.
- PRE_DEPTH=8, ckdiv=0, tready=0 for 20 cycles after trigger, pre=4, post=16 -> overrun=1, drop_count=12, 8 beats delivered, tlast on the last stored beat.
- tready toggling 1010... during POST -> tdata held on stalls, no duplicated or missing values.
- abort during POST with tvalid=1 -> next cycle state is IDLE, tvalid=0; re-arm -> overrun cleared and a fresh capture is correct.
